// File: rtl/pipe_pkg.sv
// Shared stage definitions: flag bit positions, funct3 load/store encodings,
// the memory-access FSM states and the legality check for memory ops.
package pipe_pkg;

    localparam int FLAG_REG_WRITE  = 0;
    localparam int FLAG_MEM_READ   = 1;
    localparam int FLAG_MEM_WRITE  = 2;
    localparam int FLAG_MEM_TO_REG = 3;
    localparam int FLAG_BRANCH     = 4;
    localparam int FLAG_JUMP       = 5;
    localparam int FLAG_MEM_EXC    = 6;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    function automatic logic mem_op_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic f3_ok;
        logic align_ok;
        if (wr)
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        case (f3)
            F3_H, F3_HU: align_ok = (a[0] == 1'b0);
            F3_W:        align_ok = (a == 2'b00);
            default:     align_ok = 1'b1;
        endcase
        return (rd ^ wr) && f3_ok && align_ok;
    endfunction

endpackage

// File: rtl/mem_access_s4_if.sv
// Data-memory request/grant/rvalid bus between the stage-4 unit and memory.
interface mem_access_s4_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a load word and sign/zero-extends it.
module load_align
    import pipe_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;

    assign sh = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   data = {24'h0, sh[7:0]};
            F3_H:    data = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   data = {16'h0, sh[15:0]};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_s4.sv
// Stage-4 memory access: runs loads/stores over the request/grant/rvalid bus,
// stalling the front of the pipe, and passes non-memory work straight through.
module mem_access_s4
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic [6:0]  instr_flags_in,
    input  logic [2:0]  funct3_in,
    mem_access_s4_if.master mem,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic [6:0]  instr_flags_out,
    output logic [2:0]  funct3_out,
    output logic        stall
);
    state_t      state, next_state;
    logic        is_mem, legal, start, illegal;
    logic [31:0] load_data, aligned;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;

    assign is_mem  = instr_flags_in[FLAG_MEM_READ] | instr_flags_in[FLAG_MEM_WRITE];
    assign legal   = mem_op_legal(instr_flags_in[FLAG_MEM_READ], instr_flags_in[FLAG_MEM_WRITE],
                                  funct3_in, alu_result_in[1:0]);
    assign start   = in_valid & ~flush & is_mem & legal;
    assign illegal = in_valid & is_mem & ~legal;

    load_align u_load_align (
        .rdata   (mem.mem_rdata),
        .addr_lo (alu_result_in[1:0]),
        .funct3  (funct3_in),
        .data    (aligned)
    );

    always_comb begin
        lane_strb  = '0;
        lane_wdata = '0;
        case (funct3_in)
            F3_B: begin
                lane_strb  = 4'b0001 << alu_result_in[1:0];
                lane_wdata = {4{store_data_in[7:0]}};
            end
            F3_H: begin
                lane_strb  = 4'b0011 << alu_result_in[1:0];
                lane_wdata = {2{store_data_in[15:0]}};
            end
            F3_W: begin
                lane_strb  = '1;
                lane_wdata = store_data_in;
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state      = state;
        stall           = 1'b0;
        alu_result_out  = alu_result_in;
        rd_out          = rd_in;
        instr_flags_out = instr_flags_in;
        funct3_out      = funct3_in;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = REQ;
                    stall      = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (flush)
                    next_state = IDLE;
                else if (mem.mem_gnt)
                    next_state = instr_flags_in[FLAG_MEM_WRITE] ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem.mem_rvalid)
                    next_state = flush ? IDLE : DONE;
                else if (flush)
                    next_state = DRAIN;
            end
            DRAIN: begin
                stall = 1'b1;
                if (mem.mem_rvalid)
                    next_state = IDLE;
            end
            DONE: begin
                next_state = IDLE;
                if (instr_flags_in[FLAG_MEM_READ])
                    alu_result_out = load_data;
            end
            default: next_state = IDLE;
        endcase
        // Faulting memory ops become harmless writebacks tagged with the exception bit.
        if (illegal) begin
            instr_flags_out[FLAG_MEM_EXC]   = 1'b1;
            instr_flags_out[FLAG_REG_WRITE] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            load_data     <= '0;
        end else begin
            mem.mem_req <= (next_state == REQ);
            if (state == IDLE && start) begin
                mem.mem_addr  <= {alu_result_in[31:2], 2'b00};
                mem.mem_we    <= instr_flags_in[FLAG_MEM_WRITE];
                mem.mem_wstrb <= instr_flags_in[FLAG_MEM_WRITE] ? lane_strb : 4'b0000;
                mem.mem_wdata <= lane_wdata;
            end
            if (state == WAIT && mem.mem_rvalid && !flush)
                load_data <= aligned;
        end
    end
endmodule

// File: tb/tb_mem_access_s4.sv
// Directed bench for mem_access_s4: expected stage-5 payloads are queued at
// issue time and checked when the unit releases the stall.
module tb_mem_access_s4;
    import pipe_pkg::*;

    localparam logic [6:0] FL_ALU   = 7'b0000001;
    localparam logic [6:0] FL_LOAD  = 7'b0001011;
    localparam logic [6:0] FL_STORE = 7'b0000100;
    localparam logic [6:0] FL_LD_EX = 7'b1001010;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  rd;
        logic [6:0]  flags;
        logic [2:0]  f3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  rd_in;
    logic [6:0]  instr_flags_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic [6:0]  instr_flags_out;
    logic [2:0]  funct3_out;
    logic        stall;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    mem_access_s4_if mem();

    mem_access_s4 dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .alu_result_in   (alu_result_in),
        .store_data_in   (store_data_in),
        .rd_in           (rd_in),
        .instr_flags_in  (instr_flags_in),
        .funct3_in       (funct3_in),
        .mem             (mem),
        .alu_result_out  (alu_result_out),
        .rd_out          (rd_out),
        .instr_flags_out (instr_flags_out),
        .funct3_out      (funct3_out),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_res"},   alu_result_out,         e.res);
            chk({e.tag, "_rd"},    {27'd0, rd_out},        {27'd0, e.rd});
            chk({e.tag, "_flags"}, {25'd0, instr_flags_out}, {25'd0, e.flags});
            chk({e.tag, "_f3"},    {29'd0, funct3_out},    {29'd0, e.f3});
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic [6:0] flags, input logic [2:0] f3);
        in_valid       = 1'b1;
        alu_result_in  = addr;
        store_data_in  = sdata;
        rd_in          = rd;
        instr_flags_in = flags;
        funct3_in      = f3;
    endtask

    // Same-cycle instruction: no stall and no request expected.
    task automatic pass_op(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [6:0] flags, input logic [6:0] exp_flags,
                           input logic [2:0] f3);
        @(posedge clk); #1;
        drive(addr, 32'h0, rd, flags, f3);
        sb.push_back('{tag, addr, rd, exp_flags, f3});
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req"},   {31'd0, mem.mem_req}, 32'd0);
        sb_compare();
    endtask

    task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [6:0] flags, input logic [2:0] f3, input int gnt_dly,
                          input logic [31:0] rdata, input logic [31:0] exp_res,
                          input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input int exp_stall);
        int   stalls  = 0;
        int   reqs    = 0;
        logic granted = 1'b0;
        logic done    = 1'b0;
        logic is_st   = flags[FLAG_MEM_WRITE];
        @(posedge clk); #1;
        drive(addr, sdata, 5'd9, flags, f3);
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        sb.push_back('{tag, exp_res, 5'd9, flags, f3});
        for (int c = 0; c < 30 && !done; c++) begin
            #1;
            if (!stall) begin
                sb_compare();
                chk({tag, "_stalls"}, stalls, exp_stall);
                chk({tag, "_req_done"}, {31'd0, mem.mem_req}, 32'd0);
                done = 1'b1;
            end else begin
                stalls++;
                if (mem.mem_req) begin
                    reqs++;
                    chk({tag, "_addr"}, mem.mem_addr, exp_maddr);
                    chk({tag, "_we"},   {31'd0, mem.mem_we}, {31'd0, is_st});
                    if (is_st) begin
                        chk({tag, "_strb"},  {28'd0, mem.mem_wstrb}, {28'd0, exp_strb});
                        chk({tag, "_wdata"}, mem.mem_wdata, exp_wdata);
                    end
                    if (reqs > gnt_dly) mem.mem_gnt = 1'b1;
                end else if (granted && !is_st) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = rdata;
                end
                if (mem.mem_gnt) granted = 1'b1;
                @(posedge clk); #1;
                mem.mem_gnt    = 1'b0;
                mem.mem_rvalid = 1'b0;
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        alu_result_in = 32'h0000_00A5; store_data_in = '0; rd_in = 5'd3;
        instr_flags_in = FL_ALU; funct3_in = 3'b000;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        #2;
        chk("rst_req",   {31'd0, mem.mem_req}, 32'd0);
        chk("rst_we",    {31'd0, mem.mem_we},  32'd0);
        chk("rst_addr",  mem.mem_addr,  32'd0);
        chk("rst_wdata", mem.mem_wdata, 32'd0);
        chk("rst_strb",  {28'd0, mem.mem_wstrb}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pass",  alu_result_out, 32'h0000_00A5);
        @(posedge clk); #1;
        rst = 1'b0;

        pass_op("add", 32'h0000_1234, 5'd5, FL_ALU, FL_ALU, 3'b000);
        mem_op("lb",  32'h0000_1003, 32'h0, FL_LOAD, F3_B,  0, 32'h80FF_0000,
               32'hFFFF_FF80, 32'h0000_1000, 4'h0, 32'h0, 3);
        mem_op("lbu", 32'h0000_1003, 32'h0, FL_LOAD, F3_BU, 0, 32'h80FF_0000,
               32'h0000_0080, 32'h0000_1000, 4'h0, 32'h0, 3);
        mem_op("lh",  32'h0000_1002, 32'h0, FL_LOAD, F3_H,  1, 32'h8001_1234,
               32'hFFFF_8001, 32'h0000_1000, 4'h0, 32'h0, 4);
        mem_op("lhu", 32'h0000_1000, 32'h0, FL_LOAD, F3_HU, 0, 32'h1234_9ABC,
               32'h0000_9ABC, 32'h0000_1000, 4'h0, 32'h0, 3);
        mem_op("lw",  32'h0000_1008, 32'h0, FL_LOAD, F3_W,  0, 32'hCAFE_BABE,
               32'hCAFE_BABE, 32'h0000_1008, 4'h0, 32'h0, 3);
        mem_op("sh",  32'h0000_2002, 32'hAAAA_BEEF, FL_STORE, F3_H, 2, 32'h0,
               32'h0000_2002, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 4);
        mem_op("sb",  32'h0000_2001, 32'h1234_56C3, FL_STORE, F3_B, 0, 32'h0,
               32'h0000_2001, 32'h0000_2000, 4'b0010, 32'hC3C3_C3C3, 2);
        mem_op("sw",  32'h0000_2004, 32'h1234_5678, FL_STORE, F3_W, 0, 32'h0,
               32'h0000_2004, 32'h0000_2004, 4'b1111, 32'h1234_5678, 2);
        pass_op("lw_misal", 32'h0000_3001, 5'd6, FL_LOAD, FL_LD_EX, F3_W);
        pass_op("sw_bad_f3", 32'h0000_3000, 5'd0, FL_STORE, 7'b1000100, F3_BU);

        // Load squashed in WAIT: response must be drained, not delivered.
        @(posedge clk); #1;
        drive(32'h0000_4000, 32'h0, 5'd11, FL_LOAD, F3_W);
        #1; chk("fl_idle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #2;
        chk("fl_req", {31'd0, mem.mem_req}, 32'd1);
        mem.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem.mem_gnt = 1'b0; flush = 1'b1;
        #1; chk("fl_wait_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1; chk("fl_drain_stall", {31'd0, stall}, 32'd1);
        chk("fl_drain_state", {29'd0, dut.state}, {29'd0, DRAIN});
        @(posedge clk); #2;
        chk("fl_drain_hold", {31'd0, stall}, 32'd1);
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem.mem_rvalid = 1'b0; in_valid = 1'b0;
        #1; chk("fl_idle", {29'd0, dut.state}, {29'd0, IDLE});
        chk("fl_idle_stall0", {31'd0, stall}, 32'd0);
        pass_op("fl_next", 32'h0000_0055, 5'd12, FL_ALU, FL_ALU, 3'b000);

        // Asynchronous reset while a store is pending in REQ.
        @(posedge clk); #1;
        drive(32'h0000_5000, 32'h0000_0001, 5'd0, FL_STORE, F3_W);
        @(posedge clk); #2;
        chk("rr_req", {31'd0, mem.mem_req}, 32'd1);
        #1; rst = 1'b1;
        #1;
        chk("rr_req0",  {31'd0, mem.mem_req}, 32'd0);
        chk("rr_state", {29'd0, dut.state}, {29'd0, IDLE});
        chk("rr_addr",  mem.mem_addr, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem.mem_rvalid = 1'b0;
        chk("rr_late_rvalid", {29'd0, dut.state}, {29'd0, IDLE});
        pass_op("rr_next", 32'h0000_0077, 5'd13, FL_ALU, FL_ALU, 3'b000);

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
